// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU command path: ALU opcodes, ASCII codes,
// parser state encoding and a small character-class helper.
package uart_alu_pkg;

  localparam logic [7:0] OPC_ADD = 8'h20;
  localparam logic [7:0] OPC_SUB = 8'h22;
  localparam logic [7:0] OPC_AND = 8'h24;
  localparam logic [7:0] OPC_OR  = 8'h25;
  localparam logic [7:0] OPC_XOR = 8'h26;
  localparam logic [7:0] OPC_NOR = 8'h27;
  localparam logic [7:0] OPC_SRA = 8'h03;
  localparam logic [7:0] OPC_SRL = 8'h02;

  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPA,
    ST_OPB,
    ST_OUT,
    ST_ERR
  } parser_state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage

// File: rtl/cmd_opcode_lut.sv
// Combinational operator-character decoder: ASCII byte -> ALU opcode plus a valid flag.
// Build option CMD_LOWERCASE_EN also accepts lowercase 'a','o','x','n'.
module cmd_opcode_lut
  import uart_alu_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic [7:0] opcode,
  output logic       op_ok
);

  always_comb begin
    opcode = 8'h00;
    op_ok  = 1'b1;
    case (rx_data)
      "+":     opcode = OPC_ADD;
      "-":     opcode = OPC_SUB;
      "A":     opcode = OPC_AND;
      "O":     opcode = OPC_OR;
      "X":     opcode = OPC_XOR;
      "N":     opcode = OPC_NOR;
      ">":     opcode = OPC_SRA;
      "/":     opcode = OPC_SRL;
`ifdef CMD_LOWERCASE_EN
      "a":     opcode = OPC_AND;
      "o":     opcode = OPC_OR;
      "x":     opcode = OPC_XOR;
      "n":     opcode = OPC_NOR;
`endif
      default: op_ok  = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "<A digits><op><B digits>CR" from a UART byte stream into an ALU command
// with a valid/ready handshake. Lowercase operators depend on CMD_LOWERCASE_EN (see cmd_opcode_lut).
module uart_cmd_parser
  import uart_alu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [7:0]        opcode,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  parser_state_t     state, state_next;
  logic [DATA_W-1:0] acc_a, acc_b;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic [7:0]        opcode_q;
  logic              err_q;

  logic              rx_is_digit;
  logic [3:0]        digit;
  logic [DATA_W-1:0] acc_a_mac, acc_b_mac;
  logic [7:0]        lut_opcode;
  logic              lut_op_ok;

  cmd_opcode_lut u_lut (
    .rx_data (rx_data),
    .opcode  (lut_opcode),
    .op_ok   (lut_op_ok)
  );

  // Decimal accumulate truncates to DATA_W bits, so oversized values wrap silently.
  assign rx_is_digit = is_digit(rx_data);
  assign digit       = rx_data[3:0];
  assign acc_a_mac   = acc_a * DATA_W'(10) + DATA_W'(digit);
  assign acc_b_mac   = acc_b * DATA_W'(10) + DATA_W'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rx_done) begin
          if (rx_is_digit) begin
            state_next = ST_OPA;
          end else if ((rx_data != ASCII_CR) && (rx_data != ASCII_SPACE)) begin
            state_next = ST_ERR;
          end
        end
      end
      ST_OPA: begin
        if (rx_done) begin
          if (rx_is_digit) begin
            if (cnt_a == CNT_W'(MAX_DIGITS)) state_next = ST_ERR;
          end else if (lut_op_ok) begin
            state_next = ST_OPB;
          end else begin
            state_next = ST_ERR;
          end
        end
      end
      ST_OPB: begin
        if (rx_done) begin
          if (rx_is_digit) begin
            if (cnt_b == CNT_W'(MAX_DIGITS)) state_next = ST_ERR;
          end else if ((rx_data == ASCII_CR) && (cnt_b != '0)) begin
            state_next = ST_OUT;
          end else begin
            state_next = ST_ERR;
          end
        end
      end
      ST_OUT: begin
        if (cmd_ready) state_next = ST_IDLE;
      end
      ST_ERR: begin
        if (rx_done && (rx_data == ASCII_CR)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Every return to IDLE wipes the operands so a new command always starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a    <= '0;
      acc_b    <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      opcode_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state_next == ST_ERR) && (state != ST_ERR);
      if (state_next == ST_IDLE) begin
        acc_a    <= '0;
        acc_b    <= '0;
        cnt_a    <= '0;
        cnt_b    <= '0;
        opcode_q <= 8'h00;
      end else if (rx_done && rx_is_digit) begin
        if (state == ST_IDLE) begin
          acc_a <= DATA_W'(digit);
          cnt_a <= CNT_W'(1);
        end else if ((state == ST_OPA) && (state_next == ST_OPA)) begin
          acc_a <= acc_a_mac;
          cnt_a <= cnt_a + CNT_W'(1);
        end else if ((state == ST_OPB) && (state_next == ST_OPB)) begin
          acc_b <= acc_b_mac;
          cnt_b <= cnt_b + CNT_W'(1);
        end
      end else if (rx_done && (state == ST_OPA) && lut_op_ok) begin
        opcode_q <= lut_opcode;
      end
    end
  end

  // Command fields are only exposed while presented, otherwise they read as zero.
  always_comb begin
    cmd_valid = (state == ST_OUT);
    opcode    = cmd_valid ? opcode_q : 8'h00;
    op_a      = cmd_valid ? acc_a : '0;
    op_b      = cmd_valid ? acc_b : '0;
    err       = err_q;
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (DATA_W=8, MAX_DIGITS=3);
// lowercase-operator expectations follow CMD_LOWERCASE_EN.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [7:0] opcode;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int err_count = 0;
  int both_count = 0;
  int hs0, err0;

  uart_cmd_parser #(.DATA_W(8), .MAX_DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .opcode    (opcode),
    .op_a      (op_a),
    .op_b      (op_b),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: handshakes, err-high cycles and illegal valid/err overlap.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) hs_count++;
    if (err) err_count++;
    if (cmd_valid && err) both_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    rx_data = c;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic sendChars(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  task automatic sendCmd(input string s);
    sendChars(s);
    applyStimulus(8'd13);
  endtask

  task automatic mark();
    hs0  = hs_count;
    err0 = err_count;
  endtask

  task automatic checkCmd(input string tag, input logic [7:0] eop, input logic [7:0] ea, input logic [7:0] eb);
    checkOutput({tag, "_valid"},  32'(cmd_valid), 32'd1);
    checkOutput({tag, "_opcode"}, 32'(opcode), 32'(eop));
    checkOutput({tag, "_op_a"},   32'(op_a), 32'(ea));
    checkOutput({tag, "_op_b"},   32'(op_b), 32'(eb));
    checkOutput({tag, "_err"},    32'(err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid",  32'(cmd_valid), 32'd0);
    checkOutput("rst_err",    32'(err), 32'd0);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);
    checkOutput("rst_op_a",   32'(op_a), 32'd0);
    checkOutput("rst_op_b",   32'(op_b), 32'd0);
    rst_n = 1'b1;
    idleCycles(2);

    // Basic add, one-cycle valid with ready held high.
    mark();
    sendChars("12+34");
    checkOutput("t1_no_valid_before_cr", 32'(cmd_valid), 32'd0);
    applyStimulus(8'd13);
    checkCmd("t1", 8'h20, 8'd12, 8'd34);
    idleCycles(1);
    checkOutput("t1_valid_one_cycle", 32'(cmd_valid), 32'd0);
    checkOutput("t1_handshakes", 32'(hs_count - hs0), 32'd1);

    // Operand wrap: 300 mod 256 = 44.
    mark();
    sendCmd("300X7");
    checkCmd("t2", 8'h26, 8'd44, 8'd7);
    idleCycles(1);
    checkOutput("t2_err_count", 32'(err_count - err0), 32'd0);

    // Fourth digit overflows MAX_DIGITS, rest discarded until CR.
    mark();
    sendChars("123");
    applyStimulus("4");
    checkOutput("t3_err_pulse", 32'(err), 32'd1);
    applyStimulus("+");
    checkOutput("t3_err_cleared", 32'(err), 32'd0);
    sendCmd("1");
    idleCycles(1);
    checkOutput("t3_err_count", 32'(err_count - err0), 32'd1);
    checkOutput("t3_no_handshake", 32'(hs_count - hs0), 32'd0);
    sendCmd("5-2");
    checkCmd("t3b", 8'h22, 8'd5, 8'd2);
    idleCycles(1);

    // Backpressure: outputs hold, stray byte dropped, one handshake.
    cmd_ready = 1'b0;
    mark();
    sendCmd("9>1");
    checkCmd("t4", 8'h03, 8'd9, 8'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) applyStimulus("7");
      else idleCycles(1);
      checkOutput($sformatf("t4_hold%0d_valid", i),  32'(cmd_valid), 32'd1);
      checkOutput($sformatf("t4_hold%0d_opcode", i), 32'(opcode), 32'h03);
      checkOutput($sformatf("t4_hold%0d_op_a", i),   32'(op_a), 32'd9);
      checkOutput($sformatf("t4_hold%0d_op_b", i),   32'(op_b), 32'd1);
    end
    cmd_ready = 1'b1;
    idleCycles(1);
    checkOutput("t4_released", 32'(cmd_valid), 32'd0);
    checkOutput("t4_handshakes", 32'(hs_count - hs0), 32'd1);
    checkOutput("t4_err_count", 32'(err_count - err0), 32'd0);

    // Lowercase operator, build dependent.
    mark();
    sendCmd("5a3");
`ifdef CMD_LOWERCASE_EN
    checkCmd("t5", 8'h24, 8'd5, 8'd3);
    idleCycles(1);
    checkOutput("t5_err_count", 32'(err_count - err0), 32'd0);
`else
    checkOutput("t5_no_valid", 32'(cmd_valid), 32'd0);
    idleCycles(1);
    checkOutput("t5_err_count", 32'(err_count - err0), 32'd1);
    checkOutput("t5_no_handshake", 32'(hs_count - hs0), 32'd0);
`endif

    // Missing B operand; the error CR leaves ERR pending another CR.
    mark();
    sendCmd("4+");
    idleCycles(1);
    checkOutput("t5b_no_valid", 32'(cmd_valid), 32'd0);
    checkOutput("t5b_err_count", 32'(err_count - err0), 32'd1);
    checkOutput("t5b_no_handshake", 32'(hs_count - hs0), 32'd0);
    applyStimulus(8'd13);
    idleCycles(1);
    checkOutput("t5b_resync_no_err", 32'(err_count - err0), 32'd1);

    // Leading CR/space ignored; zero operand; full-width digits with wrap.
    mark();
    applyStimulus(8'd13);
    applyStimulus(" ");
    sendCmd("7N0");
    checkCmd("t6", 8'h27, 8'd7, 8'd0);
    idleCycles(1);
    sendCmd("255/999");
    checkCmd("t6b", 8'h02, 8'd255, 8'd231);
    idleCycles(1);
    checkOutput("t6_err_count", 32'(err_count - err0), 32'd0);

    // Asynchronous reset while a command is pending.
    cmd_ready = 1'b0;
    sendCmd("12+3");
    checkOutput("t7_pending_valid", 32'(cmd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t7_rst_valid",  32'(cmd_valid), 32'd0);
    checkOutput("t7_rst_opcode", 32'(opcode), 32'd0);
    checkOutput("t7_rst_op_a",   32'(op_a), 32'd0);
    idleCycles(2);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    idleCycles(2);
    checkOutput("t7_after_release", 32'(cmd_valid), 32'd0);

    // Reset mid-command, then a fresh command.
    mark();
    sendChars("12+3");
    rst_n = 1'b0;
    #1;
    checkOutput("t8_rst_valid",  32'(cmd_valid), 32'd0);
    checkOutput("t8_rst_err",    32'(err), 32'd0);
    checkOutput("t8_rst_opcode", 32'(opcode), 32'd0);
    checkOutput("t8_rst_op_a",   32'(op_a), 32'd0);
    checkOutput("t8_rst_op_b",   32'(op_b), 32'd0);
    idleCycles(1);
    rst_n = 1'b1;
    idleCycles(2);
    checkOutput("t8_no_err_pulse", 32'(err_count - err0), 32'd0);
    checkOutput("t8_no_handshake", 32'(hs_count - hs0), 32'd0);
    sendCmd("8O1");
    checkCmd("t8", 8'h25, 8'd8, 8'd1);
    idleCycles(1);

    checkOutput("valid_err_exclusive", 32'(both_count), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
